// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Write-back end of the MEM/WB pipeline interface. Selects the write-back
// data (ALU result or load data), commits it to a 32x32 general-purpose
// register file and counts committed writes. Two zero-latency read ports
// serve the ID stage, with a same-cycle bypass of the value being written.
//
// Ports
//   clk            in   system clock, rising-edge
//   clrn           in   asynchronous active-low reset
//   wb_Alu_Result  in   [DW-1:0] ALU result from MEM/WB
//   wb_mo          in   [DW-1:0] load data from MEM/WB
//   wb_rn          in   [5:0]    destination; bit 5 set means "no write"
//   wb_m2reg       in   1 = write wb_mo, 0 = write wb_Alu_Result
//   wb_wreg        in   write enable from MEM/WB
//   rna, rnb       in   [4:0]    read port addresses
//   qa, qb         out  [DW-1:0] read port data (combinational, bypassed)
//   wb_data        out  [DW-1:0] selected write-back data (combinational)
//   commit_cnt     out  [CW-1:0] committed register writes since reset
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int CW   = 32
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [DW-1:0] wb_Alu_Result,
    input  logic [DW-1:0] wb_mo,
    input  logic [5:0]    wb_rn,
    input  logic          wb_m2reg,
    input  logic          wb_wreg,
    input  logic [4:0]    rna,
    input  logic [4:0]    rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    output logic [DW-1:0] wb_data,
    output logic [CW-1:0] commit_cnt
);

    logic [DW-1:0] regs_q [NREG];
    logic [CW-1:0] commit_cnt_q;
    logic [CW-1:0] commit_cnt_d;
    logic          commit_s;
    logic [4:0]    wr_addr_s;

    assign wr_addr_s = wb_rn[4:0];

    // Write-back data select.
    always_comb begin
        wb_data = wb_Alu_Result;
        if (wb_m2reg) begin
            wb_data = wb_mo;
        end else begin
            wb_data = wb_Alu_Result;
        end
    end

    // A write commits only when enabled, bit 5 clear and the target is not r0.
    always_comb begin
        commit_s = 1'b0;
        if (wb_wreg && !wb_rn[5] && (wr_addr_s != 5'd0)) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Next value of the committed-write counter; wraps naturally at 2^CW.
    always_comb begin
        commit_cnt_d = commit_cnt_q;
        if (commit_s) begin
            commit_cnt_d = commit_cnt_q + CW'(1);
        end else begin
            commit_cnt_d = commit_cnt_q;
        end
    end

    // Register file storage; r0 is never written so it stays zero.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit_s) begin
            regs_q[wr_addr_s] <= wb_data;
        end
    end

    // Committed-write counter register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            commit_cnt_q <= '0;
        end else begin
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign commit_cnt = commit_cnt_q;

    // Read port A: r0 reads zero, a pending write to the same address is
    // forwarded so ID sees the new value without a stall.
    always_comb begin
        qa = regs_q[rna];
        if (rna == 5'd0) begin
            qa = '0;
        end else if (wb_wreg && !wb_rn[5] && (wr_addr_s == rna)) begin
            qa = wb_data;
        end else begin
            qa = regs_q[rna];
        end
    end

    // Read port B: same rule as port A.
    always_comb begin
        qb = regs_q[rnb];
        if (rnb == 5'd0) begin
            qb = '0;
        end else if (wb_wreg && !wb_rn[5] && (wr_addr_s == rnb)) begin
            qb = wb_data;
        end else begin
            qb = regs_q[rnb];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk;
    logic        clrn;
    logic [31:0] wb_Alu_Result;
    logic [31:0] wb_mo;
    logic [5:0]  wb_rn;
    logic        wb_m2reg;
    logic        wb_wreg;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] qa, qb, wb_data, commit_cnt;
    logic [31:0] qa4, qb4, wb_data4;
    logic [3:0]  commit_cnt4;

    wb_regfile #(.DW(32), .NREG(32), .CW(32)) u_dut (
        .clk(clk), .clrn(clrn), .wb_Alu_Result(wb_Alu_Result), .wb_mo(wb_mo),
        .wb_rn(wb_rn), .wb_m2reg(wb_m2reg), .wb_wreg(wb_wreg), .rna(rna), .rnb(rnb),
        .qa(qa), .qb(qb), .wb_data(wb_data), .commit_cnt(commit_cnt)
    );

    // Narrow-counter build sharing the same stimulus, used for wrap checks.
    wb_regfile #(.DW(32), .NREG(32), .CW(4)) u_dut4 (
        .clk(clk), .clrn(clrn), .wb_Alu_Result(wb_Alu_Result), .wb_mo(wb_mo),
        .wb_rn(wb_rn), .wb_m2reg(wb_m2reg), .wb_wreg(wb_wreg), .rna(rna), .rnb(rnb),
        .qa(qa4), .qb(qb4), .wb_data(wb_data4), .commit_cnt(commit_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] qa;
        logic [31:0] qb;
        logic [31:0] wbd;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [32];
    longint      n_commits = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural read rule: r0 is zero, a write pending this cycle to the
    // address is visible, otherwise the stored value.
    function automatic logic [31:0] model_read(input logic [4:0] a, input logic live,
                                               input logic wr, input logic [5:0] rn,
                                               input logic [31:0] d);
        if (a == 5'd0) return 32'd0;
        if (live && wr && !rn[5] && rn[4:0] == a) return d;
        return mem[a];
    endfunction

    // Apply one cycle of stimulus, push the expected response, update model.
    task automatic drive(input logic rst_n_v, input logic wr, input logic m2r,
                         input logic [5:0] rn, input logic [31:0] alu,
                         input logic [31:0] mo, input logic [4:0] a, input logic [4:0] b);
        exp_t        e;
        logic [31:0] d;
        @(posedge clk);
        #1;
        clrn = rst_n_v; wb_wreg = wr; wb_m2reg = m2r; wb_rn = rn;
        wb_Alu_Result = alu; wb_mo = mo; rna = a; rnb = b;
        d = m2r ? mo : alu;
        if (!rst_n_v) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'd0;
            n_commits = 0;
        end
        e.qa   = model_read(a, rst_n_v, wr, rn, d);
        e.qb   = model_read(b, rst_n_v, wr, rn, d);
        e.wbd  = d;
        e.cnt  = 32'(n_commits);
        e.cnt4 = 4'(n_commits % 16);
        sb_q.push_back(e);
        // clrn stays at this value through the next edge.
        if (rst_n_v && wr && !rn[5] && rn[4:0] != 5'd0) begin
            mem[rn[4:0]] = d;
            n_commits++;
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("qa", qa, e.qa);
                chk("qb", qb, e.qb);
                chk("wb_data", wb_data, e.wbd);
                chk("commit_cnt", commit_cnt, e.cnt);
                chk("commit_cnt_cw4", {28'd0, commit_cnt4}, {28'd0, e.cnt4});
                chk("qa_cw4", qa4, e.qa);
            end
        end
    end

    initial begin
        logic [5:0] rn;
        logic [4:0] a, b;
        int wait_cycles;
        clrn = 1'b0; wb_wreg = 1'b0; wb_m2reg = 1'b0; wb_rn = 6'd0;
        wb_Alu_Result = 32'd0; wb_mo = 32'd0; rna = 5'd0; rnb = 5'd0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        repeat (3) @(posedge clk);

        // Reset state: every address on both ports reads zero.
        for (int i = 0; i < 16; i++)
            drive(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 5'(2 * i), 5'(2 * i + 1));

        // ALU write with bypass, then plain read.
        drive(1'b1, 1'b1, 1'b0, 6'd5, 32'h12345678, 32'h0, 5'd5, 5'd5);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0, 5'd5, 5'd0);
        // Load write to r31.
        drive(1'b1, 1'b1, 1'b1, 6'd31, 32'h1, 32'hDEADBEEF, 5'd0, 5'd31);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0, 5'd5, 5'd31);
        // Discarded writes: r0 and bit 5 set.
        drive(1'b1, 1'b1, 1'b0, 6'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 1'b0, 6'b100011, 32'hAAAA5555, 32'h0, 5'd3, 5'd0);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 5'd3);
        // Mid-operation reset with a write presented while clrn is low.
        drive(1'b1, 1'b1, 1'b0, 6'd7, 32'hCAFEF00D, 32'h0, 5'd7, 5'd7);
        drive(1'b0, 1'b1, 1'b0, 6'd9, 32'h55AA55AA, 32'h0, 5'd7, 5'd31);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0, 5'd9, 5'd7);
        // First edge after release commits normally.
        drive(1'b1, 1'b1, 1'b0, 6'd9, 32'h0BADF00D, 32'h0, 5'd9, 5'd1);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0, 5'd9, 5'd9);

        // Randomized traffic; read addresses often hit the write target.
        for (int n = 0; n < 400; n++) begin
            rn = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) rn[5] = 1'b0;
            a = ($urandom_range(0, 2) == 0) ? rn[4:0] : 5'($urandom_range(0, 31));
            b = ($urandom_range(0, 2) == 0) ? rn[4:0] : 5'($urandom_range(0, 31));
            drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rn,
                  $urandom, $urandom, a, b);
        end

        // Counter wrap on the CW=4 build: 17 commits after a reset.
        drive(1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0, 5'd1, 5'd2);
        for (int n = 0; n < 17; n++)
            drive(1'b1, 1'b1, 1'b0, 6'($urandom_range(1, 31)), $urandom, 32'h0,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        drive(1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 5'd0);

        // Let the monitor drain, bounded.
        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        checks++;
        if (commit_cnt4 !== 4'd1) begin
            errors++;
            $display("FAIL wrap_final actual=%0d expected=1", commit_cnt4);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
